// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and constants for the Wishbone memory-port arbiter.
package wb_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_ABORT = 2'b10
   } arb_state_e;

   localparam int WDOG_W = 16;

   // Registered-feedback cycle types; the arbiter never splits on them.
   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_i, wrapping.
module wb_rr_pick #(
   parameter int N    = 2,
   parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] last_i,
   output logic [N-1:0]    gnt_o,
   output logic            valid_o
);

   logic [IDXW-1:0] cand;

   // NOTE: every output gets a default before the search so no path infers a latch.
   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int off = 1; off <= N; off++) begin
         cand = IDXW'((int'(last_i) + off) % N);
         if (!valid_o && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to single-slave Wishbone arbiter with round-robin grant,
// cycle-long tenure and a watchdog that aborts stalled transfers.
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]    wbm_we_i,
   input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
   output logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]    wbm_ack_o,
   output logic [NUM_MASTERS-1:0]    wbm_err_o,
   output logic [NUM_MASTERS-1:0]    wbm_rty_o,
   output logic [AW-1:0]             wbs_adr_o,
   output logic [DW-1:0]             wbs_dat_o,
   output logic [DW/8-1:0]           wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [DW-1:0]             wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i,
   output logic [NUM_MASTERS-1:0]    grant_o,
   output logic                      timeout_o
);

   localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW   = DW / 8;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDXW-1:0]        owner_idx_q, owner_idx_d;
   logic [IDXW-1:0]        last_owner_q, last_owner_d;
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic                   timeout_q, timeout_d;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_valid;
   logic [IDXW-1:0]        pick_idx;
   logic                   owner_cyc, owner_stb, slave_resp;

   wb_rr_pick #(
      .N    (NUM_MASTERS),
      .IDXW (IDXW)
   ) u_pick (
      .req_i   (wbm_cyc_i),
      .last_i  (last_owner_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_gnt[i]) pick_idx = IDXW'(i);
      end
   end

   assign owner_cyc  = wbm_cyc_i[owner_idx_q];
   assign owner_stb  = wbm_stb_i[owner_idx_q];
   assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_idx_d  = owner_idx_q;
      last_owner_d = last_owner_q;
      wdog_d       = wdog_q;
      timeout_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            if (pick_valid) begin
               state_d     = ST_BUSY;
               grant_d     = pick_gnt;
               owner_idx_d = pick_idx;
            end
         end
         ST_BUSY: begin
            // A response in the deciding cycle wins over the watchdog.
            if (!owner_cyc) begin
               state_d      = ST_IDLE;
               grant_d      = '0;
               last_owner_d = owner_idx_q;
               wdog_d       = '0;
            end else if (slave_resp || !owner_stb) begin
               wdog_d = '0;
            end else if (wdog_q == WDOG_LAST) begin
               state_d   = ST_ABORT;
               timeout_d = 1'b1;
               wdog_d    = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_ABORT: begin
            if (!owner_cyc) begin
               state_d      = ST_IDLE;
               grant_d      = '0;
               last_owner_d = owner_idx_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         owner_idx_q  <= '0;
         last_owner_q <= IDXW'(NUM_MASTERS - 1);
         wdog_q       <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_idx_q  <= owner_idx_d;
         last_owner_q <= last_owner_d;
         wdog_q       <= wdog_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_cti_o = CTI_CLASSIC;
      wbs_bte_o = '0;
      wbm_dat_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (state_q == ST_BUSY) begin
         wbs_adr_o = wbm_adr_i[owner_idx_q*AW +: AW];
         wbs_dat_o = wbm_dat_i[owner_idx_q*DW +: DW];
         wbs_sel_o = wbm_sel_i[owner_idx_q*SW +: SW];
         wbs_we_o  = wbm_we_i[owner_idx_q];
         wbs_cyc_o = owner_cyc;
         wbs_stb_o = owner_cyc & owner_stb;
         wbs_cti_o = wbm_cti_i[owner_idx_q*3 +: 3];
         wbs_bte_o = wbm_bte_i[owner_idx_q*2 +: 2];
         // Priority ack > err > rty keeps the owner to one response per cycle.
         wbm_dat_o[owner_idx_q*DW +: DW] = wbs_dat_i;
         wbm_ack_o[owner_idx_q] = wbs_ack_i;
         wbm_err_o[owner_idx_q] = wbs_err_i & ~wbs_ack_i;
         wbm_rty_o[owner_idx_q] = wbs_rty_i & ~wbs_ack_i & ~wbs_err_i;
      end else if (state_q == ST_ABORT) begin
         wbm_err_o[owner_idx_q] = timeout_q;
      end
   end

   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed and randomized checks of wb_mem_arbiter against a round-robin model.
module tb_wb_mem_arbiter;
   import wb_mem_arbiter_pkg::*;

   localparam int NM = 2;
   localparam int TO = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 1;

   logic                 wb_clk_i = 1'b0;
   logic                 wb_rst_i;
   logic [NM*AW-1:0]     wbm_adr_i;
   logic [NM*DW-1:0]     wbm_dat_i;
   logic [NM*DW/8-1:0]   wbm_sel_i;
   logic [NM-1:0]        wbm_we_i, wbm_cyc_i, wbm_stb_i;
   logic [NM*3-1:0]      wbm_cti_i;
   logic [NM*2-1:0]      wbm_bte_i;
   logic [NM*DW-1:0]     wbm_dat_o;
   logic [NM-1:0]        wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [AW-1:0]        wbs_adr_o;
   logic [DW-1:0]        wbs_dat_o;
   logic [DW/8-1:0]      wbs_sel_o;
   logic                 wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [2:0]           wbs_cti_o;
   logic [1:0]           wbs_bte_o;
   logic [DW-1:0]        wbs_dat_i;
   logic                 wbs_ack_i, wbs_err_i, wbs_rty_i;
   logic [NM-1:0]        grant_o;
   logic                 timeout_o;

   wb_mem_arbiter #(
      .NUM_MASTERS (NM),
      .TIMEOUT     (TO),
      .AW          (AW),
      .DW          (DW)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbm_adr_i (wbm_adr_i),
      .wbm_dat_i (wbm_dat_i),
      .wbm_sel_i (wbm_sel_i),
      .wbm_we_i  (wbm_we_i),
      .wbm_cyc_i (wbm_cyc_i),
      .wbm_stb_i (wbm_stb_i),
      .wbm_cti_i (wbm_cti_i),
      .wbm_bte_i (wbm_bte_i),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_o (wbm_ack_o),
      .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_o (wbs_dat_o),
      .wbs_sel_o (wbs_sel_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_cyc_o (wbs_cyc_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_cti_o (wbs_cti_o),
      .wbs_bte_o (wbs_bte_o),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_i (wbs_ack_i),
      .wbs_err_i (wbs_err_i),
      .wbs_rty_i (wbs_rty_i),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: index of the master that most recently finished a tenure.
   logic [IW-1:0] last_owner;

   logic [AW-1:0]    adr_r [NM];
   logic [DW-1:0]    dat_r [NM];
   logic             we_r  [NM];
   logic [NM-1:0]    req, exp_g, sh;
   logic [IW-1:0]    win;
   logic [NM*DW-1:0] exp_dat;
   logic [DW-1:0]    rdat;
   int               lat, kind, stalls;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_m(input logic [IW-1:0] m, input logic cyc, input logic stb,
                          input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [2:0] cti);
      wbm_cyc_i[m]            = cyc;
      wbm_stb_i[m]            = stb;
      wbm_we_i[m]             = we;
      wbm_adr_i[m*AW +: AW]   = adr;
      wbm_dat_i[m*DW +: DW]   = dat;
      wbm_sel_i[m*4 +: 4]     = 4'hf;
      wbm_cti_i[m*3 +: 3]     = cti;
      wbm_bte_i[m*2 +: 2]     = 2'b00;
   endtask

   task automatic release_all();
      wbm_cyc_i = '0;
      wbm_stb_i = '0;
      wbm_we_i  = '0;
   endtask

   task automatic slave(input logic ack, input logic err, input logic rty, input logic [DW-1:0] dat);
      wbs_ack_i = ack;
      wbs_err_i = err;
      wbs_rty_i = rty;
      wbs_dat_i = dat;
   endtask

   // Round-robin rule: first requester searched upward from last+1, with wrap.
   function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] r, input logic [IW-1:0] last);
      logic [NM-1:0] s;
      int            idx;
      for (int off = 1; off <= NM; off++) begin
         idx = (int'(last) + off) % NM;
         s   = r >> idx;
         if (s[0]) return IW'(idx);
      end
      return '0;
   endfunction

   initial begin
      wb_rst_i  = 1'b0;
      wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
      wbm_cti_i = '0; wbm_bte_i = '0;
      release_all();
      slave(1'b0, 1'b0, 1'b0, '0);
      last_owner = IW'(NM - 1);
      repeat (3) tick();

      check("rst_grant", grant_o, '0);
      check("rst_timeout", timeout_o, 1'b0);
      check("rst_wbs_cyc", wbs_cyc_o, 1'b0);
      check("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
      wb_rst_i = 1'b1;
      tick();

      // Simultaneous request after reset: m0 first, then m1 after one dead cycle.
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'hA0A0_A0A0, CTI_CLASSIC);
      drive_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'hB1B1_B1B1, CTI_CLASSIC);
      settle();
      check("a_idle_cyc", wbs_cyc_o, 1'b0);
      tick();
      check("a_grant_m0", grant_o, 2'b01);
      check("a_cyc_rise", wbs_cyc_o, 1'b1);
      check("a_adr_m0", wbs_adr_o, 32'h0000_1000);
      slave(1'b1, 1'b0, 1'b0, 32'hDEAD_0001);
      settle();
      check("a_ack_m0", wbm_ack_o, 2'b01);
      check("a_dat_m0", wbm_dat_o, {32'h0, 32'hDEAD_0001});
      tick();
      drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
      slave(1'b0, 1'b0, 1'b0, '0);
      settle();
      check("a_drop_cyc", wbs_cyc_o, 1'b0);
      tick();
      check("a_dead_cycle", grant_o, 2'b00);
      tick();
      check("a_grant_m1", grant_o, 2'b10);
      check("a_dat_m1", wbs_dat_o, 32'hB1B1_B1B1);
      check("a_we_m1", wbs_we_o, 1'b1);
      slave(1'b1, 1'b0, 1'b0, 32'h1234_5678);
      settle();
      check("a_ack_m1", wbm_ack_o, 2'b10);
      tick();
      release_all();
      slave(1'b0, 1'b0, 1'b0, '0);
      tick();
      last_owner = 1;

      // m1 four-beat burst, m0 requests from beat 2 and must wait.
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, '0, CTI_INCR);
      tick();
      for (int beat = 0; beat < 4; beat++) begin
         drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000 + 32'(beat * 4), '0,
                 (beat == 3) ? CTI_EOB : CTI_INCR);
         if (beat == 1) drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, '0, CTI_CLASSIC);
         slave(1'b1, 1'b0, 1'b0, 32'h5000_0000 + 32'(beat));
         settle();
         check($sformatf("b_ack_beat%0d", beat), wbm_ack_o, 2'b10);
         check($sformatf("b_cti_beat%0d", beat), wbs_cti_o, (beat == 3) ? 3'b111 : 3'b010);
         check($sformatf("b_adr_beat%0d", beat), wbs_adr_o, 32'h0000_3000 + 32'(beat * 4));
         tick();
      end
      drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
      slave(1'b0, 1'b0, 1'b0, '0);
      settle();
      check("b_drop_grant", grant_o, 2'b10);
      tick();
      check("b_dead_cycle", grant_o, 2'b00);
      tick();
      check("b_grant_m0", grant_o, 2'b01);
      check("b_adr_m0", wbs_adr_o, 32'h0000_4000);
      slave(1'b1, 1'b0, 1'b0, '0);
      settle();
      check("b_ack_m0", wbm_ack_o, 2'b01);
      tick();
      release_all();
      slave(1'b0, 1'b0, 1'b0, '0);
      tick();
      last_owner = 0;

      // Stalled slave: abort after TO stalled cycles, single err and timeout pulse.
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, '0, CTI_CLASSIC);
      tick();
      stalls = 0;
      while (wbs_cyc_o === 1'b1 && stalls < 4 * TO) begin
         if (wbm_ack_o !== 2'b00) check("c_no_ack_stall", wbm_ack_o, 2'b00);
         stalls++;
         tick();
      end
      check("c_stall_cycles", stalls, TO);
      check("c_err_m1", wbm_err_o, 2'b10);
      check("c_timeout_pulse", timeout_o, 1'b1);
      check("c_ack_none", wbm_ack_o, 2'b00);
      check("c_abort_grant", grant_o, 2'b10);
      tick();
      slave(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      settle();
      check("c_err_once", wbm_err_o, 2'b00);
      check("c_timeout_once", timeout_o, 1'b0);
      check("c_late_ack_dropped", wbm_ack_o, 2'b00);
      slave(1'b0, 1'b0, 1'b0, '0);
      release_all();
      tick();
      check("c_back_idle", grant_o, 2'b00);
      last_owner = 1;

      // Ack lands on the deciding cycle: response wins, no abort.
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_6000, '0, CTI_CLASSIC);
      tick();
      repeat (TO - 1) tick();
      check("d_still_busy", wbs_cyc_o, 1'b1);
      slave(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
      settle();
      check("d_ack", wbm_ack_o, 2'b01);
      check("d_no_err", wbm_err_o, 2'b00);
      tick();
      release_all();
      slave(1'b0, 1'b0, 1'b0, '0);
      settle();
      check("d_no_timeout", timeout_o, 1'b0);
      check("d_no_err_after", wbm_err_o, 2'b00);
      tick();
      check("d_no_timeout_idle", timeout_o, 1'b0);
      last_owner = 0;

      // Reset during beat 2 of an m0 burst.
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_7000, '0, CTI_INCR);
      tick();
      check("e_grant_m0", grant_o, 2'b01);
      slave(1'b1, 1'b0, 1'b0, '0);
      tick();
      drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_7004, '0, CTI_INCR);
      wb_rst_i = 1'b0;
      tick();
      check("e_rst_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
      check("e_rst_grant", grant_o, 2'b00);
      check("e_rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
      wb_rst_i = 1'b1;
      release_all();
      slave(1'b0, 1'b0, 1'b0, '0);
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_8000, '0, CTI_CLASSIC);
      last_owner = IW'(NM - 1);
      tick();
      check("e_grant_m1", grant_o, 2'b10);
      release_all();
      tick();
      last_owner = 1;

      // Randomized single-beat tenures against the round-robin model.
      for (int it = 0; it < 16; it++) begin
         req = NM'($urandom_range(1, (1 << NM) - 1));
         for (int m = 0; m < NM; m++) begin
            adr_r[m] = $urandom;
            dat_r[m] = $urandom;
            we_r[m]  = 1'($urandom);
            sh = req >> m;
            if (sh[0]) drive_m(IW'(m), 1'b1, 1'b1, we_r[m], adr_r[m], dat_r[m], CTI_CLASSIC);
         end
         win = rr_pick(req, last_owner);
         exp_g = '0;
         exp_g[win] = 1'b1;
         tick();
         check($sformatf("r%0d_grant", it), grant_o, exp_g);
         check($sformatf("r%0d_adr", it), wbs_adr_o, adr_r[win]);
         check($sformatf("r%0d_wdat", it), wbs_dat_o, dat_r[win]);
         check($sformatf("r%0d_we", it), wbs_we_o, we_r[win]);
         lat = $urandom_range(0, TO - 3);
         repeat (lat) begin
            if (wbm_ack_o !== 2'b00) check($sformatf("r%0d_early_ack", it), wbm_ack_o, 2'b00);
            tick();
         end
         kind = $urandom_range(0, 2);
         rdat = $urandom;
         slave(kind == 0, kind == 1, kind == 2, rdat);
         settle();
         exp_dat = '0;
         exp_dat[win*DW +: DW] = rdat;
         check($sformatf("r%0d_ack", it), wbm_ack_o, (kind == 0) ? exp_g : '0);
         check($sformatf("r%0d_err", it), wbm_err_o, (kind == 1) ? exp_g : '0);
         check($sformatf("r%0d_rty", it), wbm_rty_o, (kind == 2) ? exp_g : '0);
         check($sformatf("r%0d_rdat", it), wbm_dat_o, exp_dat);
         tick();
         release_all();
         slave(1'b0, 1'b0, 1'b0, '0);
         tick();
         check($sformatf("r%0d_idle", it), grant_o, '0);
         last_owner = win;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
